// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, fetch state encoding, PC alignment helper.
package if_fetch_unit_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALTED  = 2'd2
  } fetch_state_e;

  // Instructions are halfword aligned, so bit 0 of any target is forced low.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// One-entry hold register that catches a fetch returning while ID is stalled.
module if_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_instr,
  input  logic [15:0] load_pc2,
  input  logic        drain,
  input  logic        clear,
  output logic [15:0] hold_instr,
  output logic [15:0] hold_pc2,
  output logic        hold_vld
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_instr <= NOP_INSTR;
      hold_pc2   <= 16'h0000;
      hold_vld   <= 1'b0;
    end else if (clear || drain) begin
      hold_vld <= 1'b0;
    end else if (load) begin
      hold_instr <= load_instr;
      hold_pc2   <= load_pc2;
      hold_vld   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, I-cache request handshake, IF/ID register, redirect/halt handling.
// Define IF_PERF_CNT_EN to build the fetch/flush performance counters.
//
// state      | meaning
// ST_FETCH   | normal fetch from pc (skid may hold one instruction)
// ST_DISCARD | wait out a squashed request at disc_addr, dropping its data
// ST_HALTED  | no further requests until reset
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_sel,
  input  logic [15:0] br_target,
  input  logic        id_valid,
  input  logic        halt,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc2,
  output logic        if_valid,
  output logic [15:0] fetch_cnt,
  output logic [15:0] flush_cnt
);

  fetch_state_e state;
  logic [15:0]  pc, pc_inc, disc_addr;
  logic         halt_pend;
  logic [15:0]  hold_instr, hold_pc2;
  logic         hold_vld;
  logic         adv, redir, hlt, req_miss, fetch_go;
  logic         skid_load, skid_drain, skid_clear, ifid_load;

  assign adv    = id_valid & ~stall;
  assign redir  = adv & pc_sel;
  assign hlt    = adv & halt;
  assign pc_inc = pc + 16'd2;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (rst_n) begin
      case (state)
        ST_FETCH:   imem_req = ~hold_vld;
        ST_DISCARD: begin
          imem_req  = 1'b1;
          imem_addr = disc_addr;
        end
        default:    imem_req = 1'b0;
      endcase
    end
  end

  assign req_miss   = imem_req & ~imem_rdy;
  assign fetch_go   = (state == ST_FETCH) & ~hlt & ~redir;
  assign skid_load  = fetch_go & ~hold_vld & imem_rdy & stall;
  assign skid_drain = fetch_go & hold_vld & ~stall;
  assign skid_clear = (state == ST_FETCH) & (hlt | redir);
  assign ifid_load  = fetch_go & ~stall & (hold_vld | imem_rdy);

  if_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .load_instr (imem_data),
    .load_pc2   (pc_inc),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .hold_instr (hold_instr),
    .hold_pc2   (hold_pc2),
    .hold_vld   (hold_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      disc_addr <= 16'h0000;
      halt_pend <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_pc2    <= 16'h0000;
      if_valid  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (hlt) begin
            if_valid <= 1'b0;
            if (req_miss) begin
              disc_addr <= pc;
              halt_pend <= 1'b1;
              state     <= ST_DISCARD;
            end else begin
              state <= ST_HALTED;
            end
          end else if (redir) begin
            if_valid <= 1'b0;
            pc       <= align_pc(br_target);
            if (req_miss) begin
              disc_addr <= pc;
              state     <= ST_DISCARD;
            end
          end else if (ifid_load) begin
            if_valid <= 1'b1;
            if (hold_vld) begin
              if_instr <= hold_instr;
              if_pc2   <= hold_pc2;
            end else begin
              if_instr <= imem_data;
              if_pc2   <= pc_inc;
              pc       <= pc_inc;
            end
          end else begin
            if (skid_load) pc <= pc_inc;
            if (!stall) if_valid <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if_valid <= 1'b0;
          if (redir && !hlt) pc <= align_pc(br_target);
          // A halt seen while draining takes effect once the old request completes.
          if (imem_rdy) begin
            state     <= (halt_pend || hlt) ? ST_HALTED : ST_FETCH;
            halt_pend <= 1'b0;
          end else if (hlt) begin
            halt_pend <= 1'b1;
          end
        end
        ST_HALTED: if_valid <= 1'b0;
        default: begin
          state    <= ST_FETCH;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (ifid_load) fetch_cnt <= fetch_cnt + 16'd1;
      if (redir && !hlt && (state != ST_HALTED)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign fetch_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule
